// File: rtl/char_pkg.sv
// Shared types and defaults for the character health / damage logic.
package char_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    APPLY  = 2'd1,
    INVULN = 2'd2,
    DEAD   = 2'd3
  } dmg_state_t;

  localparam logic [1:0] GAME_MENU = 2'd0;
  localparam logic [1:0] GAME_PLAY = 2'd1;

  localparam int DEF_MAX_HP        = 10;
  localparam int DEF_INVULN_FRAMES = 60;
  localparam int DEF_CONTACT_DMG   = 1;
  localparam int DEF_PROJ_DMG      = 2;
  localparam int DEF_HEAL_AMT      = 1;

  // Far edge of a box, widened to 13 bits so boxes near 4095 do not wrap.
  function automatic logic [12:0] box_far(input logic [11:0] pos, input logic [11:0] len);
    return {1'b0, pos} + {1'b0, len};
  endfunction

  function automatic logic [12:0] box_centre(input logic [11:0] pos, input logic [11:0] len);
    return {1'b0, pos} + {2'b00, len[11:1]};
  endfunction

endpackage

// File: rtl/aabb_overlap.sv
// Combinational axis-aligned box overlap test on 12-bit screen coordinates.
module aabb_overlap
  import char_pkg::*;
(
  input  logic [11:0] a_x,
  input  logic [11:0] a_y,
  input  logic [11:0] a_lng,
  input  logic [11:0] a_hgt,
  input  logic [11:0] b_x,
  input  logic [11:0] b_y,
  input  logic [11:0] b_lng,
  input  logic [11:0] b_hgt,
  output logic        overlap
);

  logic x_hit;
  logic y_hit;

  assign x_hit   = ({1'b0, a_x} < box_far(b_x, b_lng)) && ({1'b0, b_x} < box_far(a_x, a_lng));
  assign y_hit   = ({1'b0, a_y} < box_far(b_y, b_hgt)) && ({1'b0, b_y} < box_far(a_y, a_hgt));
  assign overlap = x_hit && y_hit;

endmodule

// File: rtl/char_damage_ctrl.sv
// Owns character HP: arbitrates contact/projectile damage and heals,
// runs i-frames, and flags knockback and death.
module char_damage_ctrl
  import char_pkg::*;
#(
  parameter int MAX_HP        = DEF_MAX_HP,
  parameter int INVULN_FRAMES = DEF_INVULN_FRAMES,
  parameter int CONTACT_DMG   = DEF_CONTACT_DMG,
  parameter int PROJ_DMG      = DEF_PROJ_DMG,
  parameter int HEAL_AMT      = DEF_HEAL_AMT
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [1:0]  game_active,
  input  logic        frame_tick,
  input  logic [11:0] char_x,
  input  logic [11:0] char_y,
  input  logic [11:0] char_lng,
  input  logic [11:0] char_hgt,
  input  logic [11:0] boss_x,
  input  logic [11:0] boss_y,
  input  logic [11:0] boss_lng,
  input  logic [11:0] boss_hgt,
  input  logic        proj_hit_req,
  output logic        proj_hit_ack,
  input  logic        heal_req,
  output logic [3:0]  char_hp,
  output logic        invuln,
  output logic        knockback,
  output logic        knockback_dir,
  output logic        char_dead,
  output dmg_state_t  state_dbg
);

  localparam logic [4:0] MAX_HP5  = 5'(MAX_HP);
  localparam logic [4:0] HEAL5    = 5'(HEAL_AMT);
  localparam logic [3:0] PROJ4    = 4'(PROJ_DMG);
  localparam logic [3:0] CONTACT4 = 4'(CONTACT_DMG);
  localparam logic [7:0] IFRAMES8 = 8'(INVULN_FRAMES);

  dmg_state_t  state;
  logic [7:0]  counter;
  logic [3:0]  dmg;
  logic [1:0]  ga_prev;
  logic        contact_r;
  logic        overlap;
  logic        play;
  logic        play_entry;
  logic        req_new;
  logic [4:0]  heal_sum;
  logic [3:0]  heal_val;
  logic [3:0]  sub_val;
  logic        push_right;

  aabb_overlap u_aabb (
    .a_x    (char_x),
    .a_y    (char_y),
    .a_lng  (char_lng),
    .a_hgt  (char_hgt),
    .b_x    (boss_x),
    .b_y    (boss_y),
    .b_lng  (boss_lng),
    .b_hgt  (boss_hgt),
    .overlap(overlap)
  );

  assign play       = (game_active == GAME_PLAY);
  assign play_entry = play && (ga_prev != GAME_PLAY);
  // While ack is high the requester is still holding req from the previous hit.
  assign req_new    = proj_hit_req && !proj_hit_ack;
  assign heal_sum   = {1'b0, char_hp} + HEAL5;
  assign heal_val   = (heal_sum > MAX_HP5) ? MAX_HP5[3:0] : heal_sum[3:0];
  assign sub_val    = (char_hp < dmg) ? 4'd0 : (char_hp - dmg);
  assign push_right = box_centre(char_x, char_lng) >= box_centre(boss_x, boss_lng);
  assign state_dbg  = state;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state         <= IDLE;
      char_hp       <= MAX_HP5[3:0];
      counter       <= 8'd0;
      dmg           <= 4'd0;
      ga_prev       <= GAME_MENU;
      contact_r     <= 1'b0;
      proj_hit_ack  <= 1'b0;
      invuln        <= 1'b0;
      knockback     <= 1'b0;
      knockback_dir <= 1'b0;
      char_dead     <= 1'b0;
    end else begin
      ga_prev      <= game_active;
      contact_r    <= overlap;
      proj_hit_ack <= req_new;
      knockback    <= 1'b0;
      if (play_entry) begin
        state     <= IDLE;
        char_hp   <= MAX_HP5[3:0];
        counter   <= 8'd0;
        char_dead <= 1'b0;
        invuln    <= 1'b0;
      end else if (!play) begin
        invuln <= 1'b0;
      end else begin
        case (state)
          IDLE: begin
            if (req_new) begin
              dmg   <= PROJ4;
              state <= APPLY;
            end else if (contact_r) begin
              dmg   <= CONTACT4;
              state <= APPLY;
            end else if (heal_req) begin
              char_hp <= heal_val;
            end
          end
          APPLY: begin
            char_hp       <= sub_val;
            knockback     <= 1'b1;
            knockback_dir <= push_right;
            counter       <= IFRAMES8;
            if (char_hp <= dmg) begin
              state     <= DEAD;
              char_dead <= 1'b1;
              invuln    <= 1'b0;
            end else begin
              state  <= INVULN;
              invuln <= 1'b1;
            end
          end
          INVULN: begin
            invuln <= 1'b1;
            if (counter == 8'd0) begin
              state  <= IDLE;
              invuln <= 1'b0;
            end else if (frame_tick) begin
              counter <= counter - 8'd1;
            end
            if (heal_req) char_hp <= heal_val;
          end
          DEAD: begin
            char_hp   <= 4'd0;
            char_dead <= 1'b1;
          end
          default: state <= IDLE;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_char_damage_ctrl.sv
// Bench for char_damage_ctrl: box-overlap vector table, hand sequences for
// i-frames/death/heal/respawn, and an acknowledge scoreboard.
module tb_char_damage_ctrl;
  import char_pkg::*;

  logic        clk;
  logic        rst;
  logic [1:0]  game_active;
  logic        frame_tick;
  logic [11:0] char_x, char_y, char_lng, char_hgt;
  logic [11:0] boss_x, boss_y, boss_lng, boss_hgt;
  logic        proj_hit_req;
  logic        proj_hit_ack;
  logic        heal_req;
  logic [3:0]  char_hp;
  logic        invuln;
  logic        knockback;
  logic        knockback_dir;
  logic        char_dead;
  dmg_state_t  state_dbg;

  int errors = 0;
  int checks = 0;
  logic [31:0] cyc = 0;
  logic [31:0] exp_q[$];

  typedef struct {
    logic [11:0] cx, cy, cl, ch;
    logic [11:0] bx, by, bl, bh;
    logic        hit;
    logic        dir;
  } vec_t;

  vec_t vecs[10];

  char_damage_ctrl dut (
    .clk          (clk),
    .rst          (rst),
    .game_active  (game_active),
    .frame_tick   (frame_tick),
    .char_x       (char_x),
    .char_y       (char_y),
    .char_lng     (char_lng),
    .char_hgt     (char_hgt),
    .boss_x       (boss_x),
    .boss_y       (boss_y),
    .boss_lng     (boss_lng),
    .boss_hgt     (boss_hgt),
    .proj_hit_req (proj_hit_req),
    .proj_hit_ack (proj_hit_ack),
    .heal_req     (heal_req),
    .char_hp      (char_hp),
    .invuln       (invuln),
    .knockback    (knockback),
    .knockback_dir(knockback_dir),
    .char_dead    (char_dead),
    .state_dbg    (state_dbg)
  );

  // clock / cycle stamp
  initial clk = 1'b0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // ack scoreboard: each ack must match the oldest expected cycle stamp
  always @(negedge clk) begin
    if (proj_hit_ack === 1'b1) begin
      checks++;
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL ack_unexpected: ack at cycle %0d, none expected", cyc);
      end else begin
        logic [31:0] e;
        e = exp_q.pop_front();
        if (e != cyc) begin
          errors++;
          $display("FAIL ack_cycle: got ack at %0d expected at %0d", cyc, e);
        end
      end
    end
  end

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic set_boxes(input logic [11:0] cx, cy, cl, ch, bx, by, bl, bh);
    char_x = cx; char_y = cy; char_lng = cl; char_hgt = ch;
    boss_x = bx; boss_y = by; boss_lng = bl; boss_hgt = bh;
  endtask

  task automatic boxes_apart();
    set_boxes(12'd500, 12'd500, 12'd20, 12'd20, 12'd110, 12'd105, 12'd40, 12'd40);
  endtask

  task automatic boxes_touch();
    set_boxes(12'd100, 12'd100, 12'd20, 12'd20, 12'd110, 12'd105, 12'd40, 12'd40);
  endtask

  // Requester: raise req, see ack next cycle, drop req the cycle after.
  task automatic proj_pulse();
    exp_q.push_back(cyc + 1);
    proj_hit_req = 1'b1;
    tick(2);
    proj_hit_req = 1'b0;
  endtask

  task automatic heal_pulse();
    heal_req = 1'b1;
    tick(1);
    heal_req = 1'b0;
    tick(1);
  endtask

  task automatic frame_pulses(input int n);
    repeat (n) begin
      frame_tick = 1'b1;
      tick(1);
      frame_tick = 1'b0;
      tick(1);
    end
  endtask

  task automatic contact_hit(input logic [3:0] hp_exp, input string name);
    boxes_touch();
    tick(3);
    chk(name, char_hp, hp_exp);
    chk({name, "_kb"}, knockback, 1);
    boxes_apart();
  endtask

  task automatic end_invuln();
    boxes_apart();
    frame_pulses(60);
    chk("invuln_end", invuln, 0);
  endtask

  initial begin
    vecs[0] = '{12'd100, 12'd100, 12'd20, 12'd20, 12'd110, 12'd105, 12'd40, 12'd40, 1'b1, 1'b0};
    vecs[1] = '{12'd90,  12'd100, 12'd20, 12'd20, 12'd110, 12'd105, 12'd40, 12'd40, 1'b0, 1'b0};
    vecs[2] = '{12'd91,  12'd100, 12'd20, 12'd20, 12'd110, 12'd105, 12'd40, 12'd40, 1'b1, 1'b0};
    vecs[3] = '{12'd145, 12'd100, 12'd20, 12'd20, 12'd110, 12'd105, 12'd40, 12'd40, 1'b1, 1'b1};
    vecs[4] = '{12'd150, 12'd100, 12'd20, 12'd20, 12'd110, 12'd105, 12'd40, 12'd40, 1'b0, 1'b0};
    vecs[5] = '{12'd120, 12'd145, 12'd20, 12'd20, 12'd110, 12'd105, 12'd40, 12'd40, 1'b0, 1'b0};
    vecs[6] = '{12'd120, 12'd144, 12'd20, 12'd20, 12'd110, 12'd105, 12'd40, 12'd40, 1'b1, 1'b1};
    vecs[7] = '{12'd4090, 12'd10, 12'd5, 12'd5, 12'd4000, 12'd0, 12'd200, 12'd50, 1'b1, 1'b0};
    vecs[8] = '{12'd4000, 12'd4000, 12'd200, 12'd200, 12'd50, 12'd50, 12'd30, 12'd30, 1'b0, 1'b0};
    vecs[9] = '{12'd0, 12'd0, 12'd4, 12'd4, 12'd0, 12'd0, 12'd4, 12'd4, 1'b1, 1'b1};

    // reset with overlapping boxes and play active
    rst = 1'b0; game_active = GAME_PLAY; frame_tick = 1'b0;
    proj_hit_req = 1'b0; heal_req = 1'b0;
    boxes_touch();
    tick(3);
    chk("rst_hp", char_hp, 10);
    chk("rst_invuln", invuln, 0);
    chk("rst_kb", knockback, 0);
    chk("rst_dead", char_dead, 0);
    chk("rst_ack", proj_hit_ack, 0);
    rst = 1'b1;
    tick(1);
    chk("c1_hp", char_hp, 10);
    tick(1);
    chk("c2_hp", char_hp, 10);
    chk("c2_kb", knockback, 0);
    tick(1);
    chk("first_hit_hp", char_hp, 9);
    chk("first_hit_kb", knockback, 1);
    chk("first_hit_inv", invuln, 1);
    chk("first_hit_dir", knockback_dir, 0);
    tick(1);
    chk("kb_one_cycle", knockback, 0);
    chk("inv_held", invuln, 1);

    // projectile during i-frames: acked, no damage
    proj_pulse();
    chk("inv_proj_hp", char_hp, 9);
    chk("inv_proj_kb", knockback, 0);
    boxes_apart();
    frame_pulses(59);
    chk("inv_59", invuln, 1);
    frame_pulses(1);
    chk("inv_60", invuln, 0);
    chk("inv_60_hp", char_hp, 9);

    // projectile + contact + heal together: only projectile damage
    boxes_touch();
    tick(1);
    exp_q.push_back(cyc + 1);
    proj_hit_req = 1'b1; heal_req = 1'b1;
    tick(1);
    heal_req = 1'b0;
    tick(1);
    proj_hit_req = 1'b0;
    chk("combo_hp", char_hp, 7);
    chk("combo_kb", knockback, 1);
    end_invuln();

    // walk HP down to 2, then a projectile kills
    proj_pulse();
    chk("hp_5", char_hp, 5);
    end_invuln();
    proj_pulse();
    chk("hp_3", char_hp, 3);
    end_invuln();
    contact_hit(4'd2, "hp_2");
    end_invuln();
    proj_pulse();
    chk("death_hp", char_hp, 0);
    chk("death_flag", char_dead, 1);
    chk("death_inv", invuln, 0);
    boxes_touch();
    tick(4);
    heal_pulse();
    proj_pulse();
    chk("dead_hp", char_hp, 0);
    chk("dead_flag", char_dead, 1);
    boxes_apart();
    game_active = 2'd2;
    tick(2);
    game_active = GAME_PLAY;
    tick(2);
    chk("respawn_hp", char_hp, 10);
    chk("respawn_dead", char_dead, 0);

    // heals
    heal_pulse();
    chk("heal_cap", char_hp, 10);
    contact_hit(4'd9, "heal_pre");
    heal_pulse();
    chk("heal_in_inv", char_hp, 10);
    end_invuln();
    contact_hit(4'd9, "heal_pre2");
    end_invuln();
    heal_pulse();
    chk("heal_9_10", char_hp, 10);
    contact_hit(4'd9, "heal_pre3");
    game_active = GAME_MENU;
    tick(2);
    chk("menu_inv", invuln, 0);
    heal_pulse();
    chk("menu_heal", char_hp, 9);
    proj_pulse();
    chk("menu_proj_hp", char_hp, 9);
    chk("menu_proj_kb", knockback, 0);
    game_active = GAME_PLAY;
    tick(2);
    chk("menu_respawn", char_hp, 10);

    // reset while a request is outstanding: re-acked afterwards
    exp_q.push_back(cyc + 1);
    proj_hit_req = 1'b1;
    tick(1);
    @(posedge clk);
    #1 rst = 1'b0;
    tick(1);
    chk("midrst_hp", char_hp, 10);
    chk("midrst_ack", proj_hit_ack, 0);
    rst = 1'b1;
    exp_q.push_back(cyc + 1);
    tick(1);
    proj_hit_req = 1'b0;
    tick(4);

    // box overlap vector table
    for (int i = 0; i < 10; i++) begin
      game_active = GAME_MENU;
      set_boxes(vecs[i].cx, vecs[i].cy, vecs[i].cl, vecs[i].ch,
                vecs[i].bx, vecs[i].by, vecs[i].bl, vecs[i].bh);
      tick(2);
      game_active = GAME_PLAY;
      tick(4);
      chk($sformatf("vec%0d_hp", i), char_hp, vecs[i].hit ? 32'd9 : 32'd10);
      if (vecs[i].hit) chk($sformatf("vec%0d_dir", i), knockback_dir, vecs[i].dir);
    end

    tick(3);
    chk("ack_queue_empty", exp_q.size(), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/char_damage_ctrl.md
Name: char_damage_ctrl

Overview:
- Sole owner of character health: arbitrates damage and heal requests, runs invulnerability frames, flags knockback and death.
- Sources arbitrated: boss body contact (AABB test computed here), boss projectile hits (req/ack), heal pickups.
- Drives char_hp into the character control/draw/hearts path; knockback is consumed by char_ctrl.
- Sits beside draw_char in the top level and shares its position/size buses.

Parameters:
MAX_HP, 10, reload value and heal ceiling (must be <= 15)
INVULN_FRAMES, 60, invulnerability length in frame_tick pulses (8-bit counter)
CONTACT_DMG, 1, HP removed per boss-contact hit
PROJ_DMG, 2, HP removed per projectile hit
HEAL_AMT, 1, HP added per heal_req

Ports:
clk  in  1  system clock
rst  in  1  asynchronous, active-low reset
game_active  in  2  0=menu, 1=playing, 2/3=end screens
frame_tick  in  1  one-cycle pulse per VGA frame
char_x, char_y, char_lng, char_hgt  in  12 each  character box
boss_x, boss_y, boss_lng, boss_hgt  in  12 each  boss box
proj_hit_req  in  1  projectile hit; held high until acked
proj_hit_ack  out  1  one-cycle registered acknowledge
heal_req  in  1  one-cycle heal pulse
char_hp  out  4  current health
invuln  out  1  high while in i-frames
knockback  out  1  one-cycle pulse when damage applies
knockback_dir  out  1  1 = push right (char centre x >= boss centre x)
char_dead  out  1  level, high in DEAD

Behaviour:
- Reset (rst=0, asynchronous): state IDLE, char_hp=MAX_HP, counter=0. All other outputs 0.
- Contact detection: overlap when char_x < boss_x+boss_lng, boss_x < char_x+char_lng, and the same two conditions on y. Sums are 13-bit, with no wrap. The result is registered into contact_r, so detection has 1-cycle latency.
- States: IDLE, APPLY, INVULN, DEAD. The state machine operates only while game_active==1.
- IDLE:
  - proj_hit_req=1 has priority over contact_r: latch dmg=PROJ_DMG and assert proj_hit_ack in the next cycle.
  - Otherwise, contact_r=1 latches dmg=CONTACT_DMG.
  - Either case moves to APPLY.
  - heal_req with no damage: char_hp = min(char_hp+HEAL_AMT, MAX_HP), computed 5-bit. The state stays IDLE.
- APPLY (exactly 1 cycle):
  - char_hp = max(char_hp-dmg, 0), computed 5-bit.
  - knockback=1 for this cycle; knockback_dir registered from the centre compare (x + lng>>1).
  - Counter loads INVULN_FRAMES.
  - Next state is DEAD if char_hp <= dmg, else INVULN.
- INVULN:
  - invuln=1. The counter decrements on each frame_tick; reaching 0 returns the state to IDLE in the following cycle.
  - Contact is ignored. proj_hit_req is acked and discarded.
  - heal_req is honoured as in IDLE.
- DEAD:
  - char_dead=1 and char_hp=0. All requests are ignored, but proj_hit_req is still acked.
  - Leaves DEAD only via the game_active re-entry rule below.
- Same-cycle events:
  - Projectile and contact together: only the projectile damage applies.
  - Damage and heal together: the heal is dropped.
  - Heal in APPLY: dropped.
- Handshake:
  - Every proj_hit_req is acked exactly once, 1 cycle after it is first sampled high, in any state or game_active value.
  - The requester drops req the cycle after ack. A req still high after ack counts as a new request.
- game_active != 1: the state machine is frozen and no damage or heal applies. invuln and knockback are forced to 0. char_hp holds its value.
- Transition of game_active into 1 from any other value: state IDLE, char_hp=MAX_HP, counter=0, char_dead=0. This is the respawn path.
- Reset mid-operation returns to the reset values immediately. An outstanding req is re-acked after reset.

Decomposition:
- char_pkg holds:
  - dmg_state_t enum (IDLE, APPLY, INVULN, DEAD);
  - GAME_MENU/GAME_PLAY constants for game_active;
  - default HP/damage/i-frame constants.
- One sub-module, aabb_overlap: combinational 12-bit box-overlap test. It is reusable by the hearts and boss logic.

Test Plan:
- Reset with game_active=1 and boxes overlapping from cycle 0 -> contact_r rises 1 cycle later. Then APPLY: char_hp 10->9, knockback pulse for 1 cycle, invuln=1.
- Pulse proj_hit_req during INVULN -> proj_hit_ack 1 cycle later, char_hp unchanged. After 60 frame_ticks -> invuln falls and state returns to IDLE.
- In IDLE, assert proj_hit_req, contact and heal_req in the same cycle -> single ack, char_hp drops by exactly 2 and the heal is lost.
- With char_hp=2, apply a projectile hit -> char_hp=0 and char_dead=1. Later contact and heal_req have no effect; game_active 1->2->1 -> char_hp=10, char_dead=0.
- With char_hp=10, pulse heal_req -> stays 10. From 9 -> 10. With game_active=0 -> no change.
- Hold proj_hit_req high with game_active=0 -> still acked once; char_hp unchanged, no knockback pulse.
